// File: rtl/apb_pkg.sv
// Shared APB definitions: phase encoding common to requester and completer,
// plus default bus widths.
package apb_pkg;

   localparam int ADDR_W_DEF = 5;
   localparam int DATA_W_DEF = 32;
   localparam int TIMER_W    = 8;

   typedef enum logic [1:0] {
      IDLE   = 2'b00,
      SETUP  = 2'b01,
      ACCESS = 2'b10
   } apb_state_t;

endpackage

// File: rtl/apb_wait_timer.sv
// Wait-state counter for the APB access phase; flags the cycle in which the
// number of consecutive not-ready cycles reaches TIMEOUT.
module apb_wait_timer
   import apb_pkg::*;
#(
   parameter int TIMEOUT = 16
) (
   input  logic Pclk,
   input  logic Prst,
   input  logic clear,
   input  logic enable,
   output logic expired
);

   localparam logic [TIMER_W-1:0] LIMIT = TIMER_W'(TIMEOUT);

   logic [TIMER_W-1:0] count_reg;
   logic [TIMER_W-1:0] count_inc;

   assign count_inc = count_reg + 1'b1;

   always_ff @(posedge Pclk or negedge Prst) begin
      if (!Prst) begin
         count_reg <= '0;
      end else if (clear) begin
         count_reg <= '0;
      end else if (enable) begin
         count_reg <= count_inc;
      end
   end

   // Counts the current waiting cycle, so the abort decision lands in the
   // TIMEOUT-th not-ready cycle rather than one cycle later.
   assign expired = enable && (count_inc == LIMIT);

endmodule

// File: rtl/apb_master_bridge.sv
// APB requester: single read/write commands in, APB setup/access phases out,
// one response per command with read data and an error flag.
module apb_master_bridge
   import apb_pkg::*;
#(
   parameter int ADDR_W  = ADDR_W_DEF,
   parameter int DATA_W  = DATA_W_DEF,
   parameter int TIMEOUT = 16
) (
   input  logic              Pclk,
   input  logic              Prst,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic              cmd_write,
   input  logic [ADDR_W-1:0] cmd_addr,
   input  logic [DATA_W-1:0] cmd_wdata,
   output logic              rsp_valid,
   output logic [DATA_W-1:0] rsp_rdata,
   output logic              rsp_err,
   output logic [ADDR_W-1:0] Paddr,
   output logic              Pwrite,
   output logic [DATA_W-1:0] Pwdata,
   output logic              Pselx,
   output logic              Penable,
   input  logic              Pready,
   input  logic              Pslverr,
   input  logic [DATA_W-1:0] Prdata
);

   apb_state_t        state_reg, state_next;
   logic [ADDR_W-1:0] paddr_reg;
   logic              pwrite_reg;
   logic [DATA_W-1:0] pwdata_reg;
   logic              rsp_valid_reg;
   logic              rsp_err_reg;
   logic [DATA_W-1:0] rsp_rdata_reg;

   logic accept;
   logic complete;
   logic abort;
   logic waiting;
   logic expired;

   apb_wait_timer #(
      .TIMEOUT (TIMEOUT)
   ) u_timer (
      .Pclk    (Pclk),
      .Prst    (Prst),
      .clear   (accept),
      .enable  (waiting),
      .expired (expired)
   );

   always_ff @(posedge Pclk or negedge Prst) begin
      if (!Prst) begin
         state_reg <= IDLE;
      end else begin
         state_reg <= state_next;
      end
   end

   always_comb begin
      state_next = state_reg;
      cmd_ready  = 1'b0;
      Pselx      = 1'b0;
      Penable    = 1'b0;
      complete   = 1'b0;
      abort      = 1'b0;
      waiting    = 1'b0;
      case (state_reg)
         IDLE: begin
            cmd_ready = 1'b1;
            if (cmd_valid) begin
               state_next = SETUP;
            end
         end
         SETUP: begin
            Pselx      = 1'b1;
            state_next = ACCESS;
         end
         ACCESS: begin
            Pselx   = 1'b1;
            Penable = 1'b1;
            if (Pready) begin
               cmd_ready  = 1'b1;
               complete   = 1'b1;
               state_next = cmd_valid ? SETUP : IDLE;
            end else begin
               waiting = 1'b1;
               if (expired) begin
                  abort      = 1'b1;
                  state_next = IDLE;
               end
            end
         end
         default: begin
            state_next = IDLE;
         end
      endcase
      accept = cmd_valid && cmd_ready;
   end

   always_ff @(posedge Pclk or negedge Prst) begin
      if (!Prst) begin
         paddr_reg     <= '0;
         pwrite_reg    <= 1'b0;
         pwdata_reg    <= '0;
         rsp_valid_reg <= 1'b0;
         rsp_err_reg   <= 1'b0;
         rsp_rdata_reg <= '0;
      end else begin
         if (accept) begin
            paddr_reg  <= cmd_addr;
            pwrite_reg <= cmd_write;
            pwdata_reg <= cmd_wdata;
         end
         rsp_valid_reg <= complete || abort;
         if (complete) begin
            rsp_err_reg   <= Pslverr;
            rsp_rdata_reg <= (!pwrite_reg && !Pslverr) ? Prdata : '0;
         end else if (abort) begin
            rsp_err_reg   <= 1'b1;
            rsp_rdata_reg <= '0;
         end
      end
   end

   assign Paddr     = paddr_reg;
   assign Pwrite    = pwrite_reg;
   assign Pwdata    = pwdata_reg;
   assign rsp_valid = rsp_valid_reg;
   assign rsp_err   = rsp_err_reg;
   assign rsp_rdata = rsp_rdata_reg;

endmodule
